// File: rtl/spc7110_dataport.sv
// -----------------------------------------------------------------------------
// spc7110_dataport
//
// SPC7110 Data ROM read port, mapped at $00-3F/80-BF:$4810-$481A. Holds the
// base/offset/step/mode registers and a one-byte prefetch latch. The latch is
// refilled from SRAM0 through the memory arbiter (req/ack handshake) whenever
// the effective address may have changed, and is served to the SNES on $4810
// reads with auto-increment.
//
// Optional feature (macro SPC7110_DP_SIGNED_EN): when defined and mode[3]=1,
// offset and step are sign-extended from bit 15 to 24 bits. When undefined,
// both are always zero-extended; mode[3] is still stored and read back.
//
// Parameters
//   DROM_BASE    SRAM0 byte address of DROM byte 0
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   dp_enable    decoder select: SNES access within $4810-$481F
//   reg_addr     SNES_ADDR[3:0]
//   reg_we       one-cycle write strobe (qualified by dp_enable)
//   reg_re       one-cycle read strobe (qualified by dp_enable)
//   reg_din      SNES write data
//   reg_dout     SNES read data, registered (valid the cycle after reg_re)
//   drom_mask    DROM size mask from the MCU
//   rom_rd_req   fetch request to the arbiter
//   rom_rd_addr  fetch address, stable while rom_rd_req is high
//   rom_rd_ack   one-cycle grant; rom_rd_data valid in that cycle
//   rom_rd_data  fetched byte
//   busy         fetch outstanding or refetch pending
// -----------------------------------------------------------------------------
module spc7110_dataport #(
  parameter logic [23:0] DROM_BASE = 24'h100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dp_enable,
  input  logic [3:0]  reg_addr,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic [23:0] drom_mask,
  output logic        rom_rd_req,
  output logic [23:0] rom_rd_addr,
  input  logic        rom_rd_ack,
  input  logic [7:0]  rom_rd_data,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state;
  logic        refetch;
  logic [23:0] base,   base_nxt;
  logic [15:0] offset, offset_nxt;
  logic [15:0] step,   step_nxt;
  logic [7:0]  mode,   mode_nxt;
  logic [7:0]  latch;
  logic [7:0]  dout_nxt;
  logic        trigger;
  logic        sgn_cur, sgn_nxt;
  logic [15:0] amt;
  logic [23:0] eff_nxt;
  logic [23:0] addr_nxt;

  // Widen a 16-bit offset/step to the 24-bit address space.
  function automatic logic [23:0] ext16(input logic [15:0] v, input logic sgn);
    return {(sgn ? {8{v[15]}} : 8'h00), v};
  endfunction

`ifdef SPC7110_DP_SIGNED_EN
  assign sgn_cur = mode[3];
  assign sgn_nxt = mode_nxt[3];
`else
  assign sgn_cur = 1'b0;
  assign sgn_nxt = 1'b0;
`endif

  assign amt = mode[0] ? step : 16'h0001;

  // Next register state and prefetch trigger for the current SNES access.
  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    base_nxt   = base;
    offset_nxt = offset;
    step_nxt   = step;
    mode_nxt   = mode;
    dout_nxt   = reg_dout;
    trigger    = 1'b0;
    if (dp_enable && reg_we) begin
      unique case (reg_addr)
        4'h1: base_nxt[7:0]    = reg_din;
        4'h2: base_nxt[15:8]   = reg_din;
        4'h3: begin base_nxt[23:16] = reg_din; trigger = 1'b1; end
        4'h4: offset_nxt[7:0]  = reg_din;
        4'h5: begin offset_nxt[15:8] = reg_din; trigger = 1'b1; end
        4'h6: step_nxt[7:0]    = reg_din;
        4'h7: step_nxt[15:8]   = reg_din;
        4'h8: begin mode_nxt = reg_din; trigger = 1'b1; end
        default: ;
      endcase
    end else if (dp_enable && reg_re) begin
      unique case (reg_addr)
        4'h0: begin
          // Served from the latch as-is, even if a fetch is still in flight.
          dout_nxt = latch;
          if (mode[4]) offset_nxt = offset + amt;
          else         base_nxt   = base + ext16(amt, sgn_cur);
          trigger = 1'b1;
        end
        4'h1: dout_nxt = base[7:0];
        4'h2: dout_nxt = base[15:8];
        4'h3: dout_nxt = base[23:16];
        4'h4: dout_nxt = offset[7:0];
        4'h5: dout_nxt = offset[15:8];
        4'h6: dout_nxt = step[7:0];
        4'h7: dout_nxt = step[15:8];
        4'h8: dout_nxt = mode;
        4'hA: begin
          dout_nxt = 8'h00;
          if (mode[5]) begin
            base_nxt = base + ext16(offset, sgn_cur);
            trigger  = 1'b1;
          end
        end
        default: dout_nxt = 8'h00;
      endcase
    end
  end

  // Fetch address is built from the post-update registers so a trigger and
  // its register change take effect in the same cycle.
  assign eff_nxt  = base_nxt + (mode_nxt[1] ? ext16(offset_nxt, sgn_nxt) : 24'h000000);
  assign addr_nxt = (eff_nxt & drom_mask) + DROM_BASE;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base        <= '0;
      offset      <= '0;
      step        <= '0;
      mode        <= '0;
      latch       <= 8'h00;
      reg_dout    <= 8'h00;
      rom_rd_addr <= '0;
      refetch     <= 1'b0;
      state       <= S_IDLE;
    end else begin
      base     <= base_nxt;
      offset   <= offset_nxt;
      step     <= step_nxt;
      mode     <= mode_nxt;
      reg_dout <= dout_nxt;
      unique case (state)
        S_IDLE: begin
          // A stray ack while idle is ignored.
          if (trigger) begin
            state       <= S_REQ;
            rom_rd_addr <= addr_nxt;
          end
        end
        S_REQ: begin
          if (rom_rd_ack) begin
            latch   <= rom_rd_data;
            refetch <= 1'b0;
            // Pending (or coincident) triggers collapse into one new request
            // issued straight after the grant; the address only moves here.
            if (refetch || trigger) rom_rd_addr <= addr_nxt;
            else                    state       <= S_IDLE;
          end else if (trigger) begin
            refetch <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom_rd_req = (state == S_REQ);
  assign busy       = (state != S_IDLE) || refetch;

endmodule

// File: tb/tb_spc7110_dataport.sv
// -----------------------------------------------------------------------------
// tb_spc7110_dataport
//
// Directed testbench for spc7110_dataport. Inputs change on the falling edge,
// the DUT samples on the rising edge, and outputs are checked on the next
// falling edge. Expected values are hand-computed constants.
// Define SPC7110_DP_SIGNED_EN for both files to exercise the signed build.
// -----------------------------------------------------------------------------
module tb_spc7110_dataport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dp_enable = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [7:0]  reg_din = 8'h00;
  logic [7:0]  reg_dout;
  logic [23:0] drom_mask = 24'hFFFFFF;
  logic        rom_rd_req;
  logic [23:0] rom_rd_addr;
  logic        rom_rd_ack = 1'b0;
  logic [7:0]  rom_rd_data = 8'h00;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  spc7110_dataport #(.DROM_BASE(24'h100000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dp_enable   (dp_enable),
    .reg_addr    (reg_addr),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_din     (reg_din),
    .reg_dout    (reg_dout),
    .drom_mask   (drom_mask),
    .rom_rd_req  (rom_rd_req),
    .rom_rd_addr (rom_rd_addr),
    .rom_rd_ack  (rom_rd_ack),
    .rom_rd_data (rom_rd_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    dp_enable = 1'b1; reg_we = 1'b1; reg_addr = a; reg_din = d;
    @(negedge clk);
    dp_enable = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    dp_enable = 1'b1; reg_re = 1'b1; reg_addr = a;
    @(negedge clk);
    dp_enable = 1'b0; reg_re = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    rom_rd_ack = 1'b1; rom_rd_data = d;
    @(negedge clk);
    rom_rd_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dout", reg_dout, 8'h00);
    check("rst_req",  rom_rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", rom_rd_addr, 24'h000000);
    rst_n = 1'b1;
    @(negedge clk);

    // Base write; the high byte starts the fetch.
    wr(4'h1, 8'h56); wr(4'h2, 8'h34);
    check("no_trig_lo", rom_rd_req, 1'b0);
    wr(4'h3, 8'h12);
    check("base_req",  rom_rd_req, 1'b1);
    check("base_addr", rom_rd_addr, 24'h223456);
    check("base_busy", busy, 1'b1);
    ack(8'hA5);
    check("ack_req",  rom_rd_req, 1'b0);
    check("ack_busy", busy, 1'b0);

    // $4810 read with default step of 1.
    rd(4'h0);
    check("rd0_dout", reg_dout, 8'hA5);
    check("rd0_addr", rom_rd_addr, 24'h223457);
    check("rd0_req",  rom_rd_req, 1'b1);
    rd(4'h1);
    check("base_lo_rb", reg_dout, 8'h57);
    ack(8'h5A);

    // Offset addressing with step 4.
    wr(4'h8, 8'h03); ack(8'h00);
    wr(4'h4, 8'h10); wr(4'h5, 8'h00); ack(8'h00);
    wr(4'h6, 8'h04); wr(4'h7, 8'h00);
    wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
    check("ofs_addr", rom_rd_addr, 24'h100010);
    ack(8'h77);
    rd(4'h0);
    check("step_dout", reg_dout, 8'h77);
    check("step_addr", rom_rd_addr, 24'h100014);
    ack(8'h88);
    rd(4'h8);
    check("mode_rb", reg_dout, 8'h03);

    // Increment target = offset, 16-bit wrap; base untouched.
    wr(4'h8, 8'h10); ack(8'h00);
    wr(4'h4, 8'hFF); wr(4'h5, 8'hFF); ack(8'h00);
    rd(4'h0); ack(8'h00);
    rd(4'h4); check("ofs_wrap_lo", reg_dout, 8'h00);
    rd(4'h5); check("ofs_wrap_hi", reg_dout, 8'h00);
    rd(4'h1); check("base_keep",   reg_dout, 8'h04);

    // Base 24-bit wrap.
    wr(4'h8, 8'h00); ack(8'h00);
    wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'h3, 8'hFF); ack(8'h00);
    rd(4'h0);
    check("base_wrap_addr", rom_rd_addr, 24'h100000);
    ack(8'h00);
    rd(4'h3); check("base_wrap_hi", reg_dout, 8'h00);

    // Trigger during REQ: address held, one refetch after the grant.
    wr(4'h1, 8'h20); wr(4'h3, 8'h00);
    check("rf_addr0", rom_rd_addr, 24'h100020);
    wr(4'h3, 8'h05);
    wr(4'h5, 8'h00);
    check("rf_addr_held", rom_rd_addr, 24'h100020);
    check("rf_busy", busy, 1'b1);
    ack(8'h11);
    check("rf_req",  rom_rd_req, 1'b1);
    check("rf_addr", rom_rd_addr, 24'h150020);
    ack(8'h22);
    check("rf_done_req",  rom_rd_req, 1'b0);
    check("rf_done_busy", busy, 1'b0);
    rd(4'h0);
    check("rf_dout", reg_dout, 8'h22);
    // Read while busy returns the stale latch but still increments.
    rd(4'h0);
    check("stale_dout", reg_dout, 8'h22);
    ack(8'h33);
    check("stale_addr", rom_rd_addr, 24'h150022);
    ack(8'h44);

    // Simultaneous grant and trigger.
    wr(4'h3, 8'h05);
    check("sim_addr0", rom_rd_addr, 24'h150022);
    dp_enable = 1'b1; reg_we = 1'b1; reg_addr = 4'h3; reg_din = 8'h00;
    rom_rd_ack = 1'b1; rom_rd_data = 8'h55;
    @(negedge clk);
    dp_enable = 1'b0; reg_we = 1'b0; rom_rd_ack = 1'b0;
    check("sim_req",  rom_rd_req, 1'b1);
    check("sim_addr", rom_rd_addr, 24'h100022);
    rd(4'h0);
    check("sim_latch", reg_dout, 8'h55);
    ack(8'h66);
    check("sim_rf_addr", rom_rd_addr, 24'h100023);
    ack(8'h77);

    // $481A read adds offset to base.
    wr(4'h4, 8'h10); wr(4'h5, 8'h00); ack(8'h00);
    wr(4'h8, 8'h22);
    check("m22_addr", rom_rd_addr, 24'h100033);
    ack(8'h00);
    rd(4'hA);
    check("r1a_dout", reg_dout, 8'h00);
    check("r1a_addr", rom_rd_addr, 24'h100043);
    ack(8'h00);

    // Reset mid-request drops REQ asynchronously; late ack ignored.
    wr(4'h3, 8'h00);
    check("pre_rst_req", rom_rd_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req",  rom_rd_req, 1'b0);
    check("async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ack(8'h99);
    check("late_ack_req", rom_rd_req, 1'b0);
    rd(4'h0);
    check("late_ack_latch", reg_dout, 8'h00);
    ack(8'h00);

    // Step FFFF with mode[3]: signed decrements, unsigned adds 0x00FFFF.
    wr(4'h8, 8'h09); ack(8'h00);
    wr(4'h6, 8'hFF); wr(4'h7, 8'hFF);
    wr(4'h1, 8'h10); wr(4'h2, 8'h00); wr(4'h3, 8'h00); ack(8'h00);
    rd(4'h0); ack(8'h00);
    rd(4'h1); check("sgn_base_lo", reg_dout, 8'h0F);
    rd(4'h3);
`ifdef SPC7110_DP_SIGNED_EN
    check("sgn_base_hi", reg_dout, 8'h00);
`else
    check("sgn_base_hi", reg_dout, 8'h01);
`endif

    // DROM mask applied before adding the DROM base.
    drom_mask = 24'h00FFFF;
    wr(4'h3, 8'hAB);
    check("mask_addr", rom_rd_addr, 24'h10000F);
    ack(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
